// File: rtl/freq_m_ctrl.sv
// Gate-time frequency measurement controller: clears, gates and samples an external counter, scaling to Hz.
// Optional overflow reporting is enabled with the FREQ_M_CTRL_OVF_EN macro.
module freq_m_ctrl #(
    parameter int unsigned FREQ_BASE     = 200_000_000,
    parameter int unsigned CLR_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk_base,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont_mode,
    input  logic        abort,
    input  logic [1:0]  gate_sel,
    input  logic [31:0] cnt_in,
    input  logic        ovf_in,
    input  logic        result_ack,
    output logic        cnt_clr,
    output logic        gate,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        overrun
`ifdef FREQ_M_CTRL_OVF_EN
    ,
    output logic        ovf
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_CAPTURE, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] phase_q, phase_d;
    logic [31:0] gate_len_q;
    logic [1:0]  sel_q;
    logic        enter_clear;
    logic        capture;
    logic [38:0] scaled;
    logic        saturate;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        enter_clear = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if ((start || cont_mode) && !abort) begin
                    state_d     = S_CLEAR;
                    phase_d     = 32'(CLR_CYCLES - 1);
                    enter_clear = 1'b1;
                end
            end
            S_CLEAR: begin
                if (phase_q == '0) begin
                    state_d = S_GATE;
                    phase_d = gate_len_q - 32'd1;
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            S_GATE: begin
                if (phase_q == '0) begin
                    state_d = S_SETTLE;
                    phase_d = 32'(SETTLE_CYCLES - 1);
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            S_SETTLE: begin
                if (phase_q == '0) state_d = S_CAPTURE;
                else               phase_d = phase_q - 32'd1;
            end
            S_CAPTURE: state_d = S_DONE;
            S_DONE: begin
                if (cont_mode) begin
                    state_d     = S_CLEAR;
                    phase_d     = 32'(CLR_CYCLES - 1);
                    enter_clear = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides any progress and also suppresses a pending capture.
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            phase_d     = '0;
            enter_clear = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_base) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            gate_len_q <= '0;
            sel_q      <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (enter_clear) begin
                unique case (gate_sel)
                    2'd1:    begin gate_len_q <= 32'(FREQ_BASE / 10);  sel_q <= 2'd1; end
                    2'd2:    begin gate_len_q <= 32'(FREQ_BASE / 100); sel_q <= 2'd2; end
                    default: begin gate_len_q <= 32'(FREQ_BASE);       sel_q <= 2'd0; end
                endcase
            end
        end
    end

    always_comb begin
        unique case (sel_q)
            2'd1:    scaled = {7'd0, cnt_in} * 39'd10;
            2'd2:    scaled = {7'd0, cnt_in} * 39'd100;
            default: scaled = {7'd0, cnt_in};
        endcase
    end

    assign capture = (state_q == S_CAPTURE) && !abort;
    assign cnt_clr = (state_q == S_CLEAR);
    assign gate    = (state_q == S_GATE);
    assign busy    = (state_q != S_IDLE);

`ifdef FREQ_M_CTRL_OVF_EN
    logic ovf_flag;

    always_ff @(posedge clk_base) begin
        if (!rst_n)                          ovf_flag <= 1'b0;
        else if (state_q == S_CLEAR)         ovf_flag <= 1'b0;
        else if (state_q == S_GATE && ovf_in) ovf_flag <= 1'b1;
        else if (capture)                    ovf_flag <= 1'b0;
    end

    assign saturate = (|scaled[38:32]) || ovf_flag;
`else
    logic unused_ovf_in;

    assign unused_ovf_in = ovf_in;
    assign saturate      = |scaled[38:32];
`endif

    // Capture beats a same-cycle acknowledge.
    always_ff @(posedge clk_base) begin
        if (!rst_n) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
`ifdef FREQ_M_CTRL_OVF_EN
            ovf          <= 1'b0;
`endif
        end else if (capture) begin
            result       <= saturate ? 32'hFFFF_FFFF : scaled[31:0];
            result_valid <= 1'b1;
            if (result_valid && !result_ack) overrun <= 1'b1;
`ifdef FREQ_M_CTRL_OVF_EN
            if (ovf_flag) ovf <= 1'b1;
`endif
        end else if (result_ack) begin
            result_valid <= 1'b0;
            overrun      <= 1'b0;
`ifdef FREQ_M_CTRL_OVF_EN
            ovf          <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_freq_m_ctrl.sv
// Self-checking bench for freq_m_ctrl with FREQ_BASE=1000; randomized measurements against a gate-time model.
module tb_freq_m_ctrl;

    localparam int unsigned FB  = 1000;
    localparam int unsigned CLR = 4;
    localparam int unsigned SET = 4;

    logic        clk_base = 1'b0;
    logic        rst_n, start, cont_mode, abort, ovf_in, result_ack;
    logic [1:0]  gate_sel;
    logic [31:0] cnt_in;
    logic        cnt_clr, gate, busy, result_valid, overrun;
    logic [31:0] result;
`ifdef FREQ_M_CTRL_OVF_EN
    logic        ovf;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_result  = '0;
    logic        exp_valid   = 1'b0;
    logic        exp_overrun = 1'b0;

    freq_m_ctrl #(.FREQ_BASE(FB), .CLR_CYCLES(CLR), .SETTLE_CYCLES(SET)) dut (
        .clk_base(clk_base), .rst_n(rst_n), .start(start), .cont_mode(cont_mode),
        .abort(abort), .gate_sel(gate_sel), .cnt_in(cnt_in), .ovf_in(ovf_in),
        .result_ack(result_ack), .cnt_clr(cnt_clr), .gate(gate), .busy(busy),
        .result(result), .result_valid(result_valid), .overrun(overrun)
`ifdef FREQ_M_CTRL_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk_base = ~clk_base;

    task automatic tick();
        @(posedge clk_base);
        #1;
    endtask

    // Frequency in Hz = count during the gate scaled to one second, clipped to 32 bits.
    function automatic logic [31:0] expect_freq(input logic [1:0] sel, input logic [31:0] val);
        logic [63:0] p;
        case (sel)
            2'd1:    p = 64'(val) * 64'd10;
            2'd2:    p = 64'(val) * 64'd100;
            default: p = 64'(val);
        endcase
        return (p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
    endfunction

    function automatic int gate_cycles(input logic [1:0] sel);
        case (sel)
            2'd1:    return int'(FB / 10);
            2'd2:    return int'(FB / 100);
            default: return int'(FB);
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        checks++; if (result !== exp_result) begin failures++; $display("FAIL %s result: got %0h expected %0h", tag, result, exp_result); end
        checks++; if (result_valid !== exp_valid) begin failures++; $display("FAIL %s result_valid: got %0b expected %0b", tag, result_valid, exp_valid); end
        checks++; if (overrun !== exp_overrun) begin failures++; $display("FAIL %s overrun: got %0b expected %0b", tag, overrun, exp_overrun); end
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        exp_valid = 1'b0;
        exp_overrun = 1'b0;
        check_outputs("ack");
`ifdef FREQ_M_CTRL_OVF_EN
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ack ovf: got %0b expected 0", ovf); end
`endif
    endtask

    // One measurement from IDLE; optional noise on start/gate_sel during the gate, optional ack in CAPTURE.
    task automatic run_meas(input logic [1:0] sel, input logic [31:0] val, input bit ack_cap, input bit noise);
        int gl, clr_n, gate_n, first_v, fall;
        bit valid_before;
        gl = gate_cycles(sel);
        clr_n = 0; gate_n = 0; first_v = -1; fall = -1;
        valid_before = exp_valid;
        start = 1'b1; gate_sel = sel; cnt_in = val;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc <= 1100; cyc++) begin
            if (cnt_clr) clr_n++;
            if (gate) gate_n++;
            if (result_valid && first_v < 0) first_v = cyc;
            if (!busy) begin fall = cyc; break; end
            start = noise && gate && ($urandom_range(0, 3) == 0);
            if (noise) gate_sel = 2'($urandom);
            result_ack = ack_cap && (cyc == int'(CLR + SET) + gl);
            tick();
        end
        start = 1'b0; result_ack = 1'b0;
        if (exp_valid && !ack_cap) exp_overrun = 1'b1;
        exp_valid = 1'b1;
        exp_result = expect_freq(sel, val);
        checks++; if (fall !== int'(CLR + SET) + gl + 2) begin failures++; $display("FAIL meas busy_len sel=%0d: got %0d expected %0d", sel, fall, int'(CLR + SET) + gl + 2); end
        checks++; if (clr_n !== int'(CLR)) begin failures++; $display("FAIL meas clr_len: got %0d expected %0d", clr_n, CLR); end
        checks++; if (gate_n !== gl) begin failures++; $display("FAIL meas gate_len sel=%0d: got %0d expected %0d", sel, gate_n, gl); end
        if (!valid_before) begin
            checks++; if (first_v !== int'(CLR + SET) + gl + 1) begin failures++; $display("FAIL meas valid_cycle: got %0d expected %0d", first_v, int'(CLR + SET) + gl + 1); end
        end
        check_outputs("meas");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if ({cnt_clr, gate, busy} !== 3'b000) begin failures++; $display("FAIL reset ctrl: got %b expected 000", {cnt_clr, gate, busy}); end
        check_outputs("reset");
`ifdef FREQ_M_CTRL_OVF_EN
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset ovf: got %0b expected 0", ovf); end
`endif
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset idle busy: got %0b expected 0", busy); end
    endtask

    task automatic test_measure();
        logic [31:0] v;
        logic [1:0]  s;
        run_meas(2'd0, 32'd1234, 1'b0, 1'b0);
        do_ack();
        run_meas(2'd2, 32'h0300_0000, 1'b0, 1'b0);
        do_ack();
        for (int i = 0; i < 6; i++) begin
            s = 2'($urandom_range(1, 3));
            v = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 42_949_672);
            run_meas(s, v, 1'b0, 1'b1);
            if ($urandom_range(0, 1) == 1) do_ack();
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        run_meas(2'd2, $urandom_range(0, 1000), 1'b0, 1'b0);
        run_meas(2'd1, $urandom_range(0, 1000), 1'b1, 1'b1);
        run_meas(2'd2, $urandom_range(0, 1000), 1'b0, 1'b0);
        do_ack();
    endtask

    task automatic test_cont_mode();
        logic [31:0] a, b;
        bit seen;
        a = $urandom_range(0, 50_000_000);
        b = $urandom;
        gate_sel = 2'd2; cnt_in = a; cont_mode = 1'b1;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin tick(); seen = result_valid; end
        checks++; if (!seen) begin failures++; $display("FAIL cont first_capture: got timeout expected result_valid"); end
        exp_valid = 1'b1; exp_result = expect_freq(2'd2, a);
        check_outputs("cont_first");
        cnt_in = b;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin tick(); seen = overrun; end
        checks++; if (!seen) begin failures++; $display("FAIL cont second_capture: got timeout expected overrun"); end
        cont_mode = 1'b0;
        exp_overrun = 1'b1; exp_result = expect_freq(2'd2, b);
        check_outputs("cont_second");
        for (int c = 0; c < 100 && busy; c++) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont stop busy: got %0b expected 0", busy); end
        do_ack();
    endtask

    task automatic test_abort();
        int gate_n;
        run_meas(2'd2, 32'd77, 1'b0, 1'b0);
        start = 1'b1; gate_sel = 2'd0; cnt_in = $urandom;
        tick();
        start = 1'b0;
        gate_n = 0;
        for (int c = 0; c < 700; c++) begin
            if (gate) gate_n++;
            if (gate_n == 500) break;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if ({cnt_clr, gate, busy} !== 3'b000) begin failures++; $display("FAIL abort ctrl: got %b expected 000", {cnt_clr, gate, busy}); end
        check_outputs("abort");
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_start busy: got %0b expected 0", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_start later busy: got %0b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; gate_sel = 2'd1; cnt_in = $urandom;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20 && !gate; c++) tick();
        checks++; if (gate !== 1'b1) begin failures++; $display("FAIL rst_mid gate_open: got %0b expected 1", gate); end
        rst_n = 1'b0;
        tick();
        exp_result = '0; exp_valid = 1'b0; exp_overrun = 1'b0;
        checks++; if ({cnt_clr, gate, busy} !== 3'b000) begin failures++; $display("FAIL rst_mid ctrl: got %b expected 000", {cnt_clr, gate, busy}); end
        check_outputs("rst_mid");
        rst_n = 1'b1;
        for (int c = 0; c < 120; c++) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid no_restart busy: got %0b expected 0", busy); end
        check_outputs("rst_mid_after");
    endtask

    task automatic test_ovf();
        start = 1'b1; gate_sel = 2'd2; cnt_in = 32'd5;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10 && !gate; c++) tick();
        ovf_in = 1'b1;
        tick();
        ovf_in = 1'b0;
        for (int c = 0; c < 40 && busy; c++) tick();
        exp_valid = 1'b1;
`ifdef FREQ_M_CTRL_OVF_EN
        exp_result = 32'hFFFF_FFFF;
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf flag: got %0b expected 1", ovf); end
`else
        exp_result = 32'd500;
`endif
        check_outputs("ovf");
        do_ack();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cont_mode = 1'b0; abort = 1'b0;
        ovf_in = 1'b0; result_ack = 1'b0; gate_sel = 2'd0; cnt_in = '0;
        test_reset();
        test_measure();
        test_back_to_back();
        test_cont_mode();
        test_abort();
        test_reset_mid();
        test_ovf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
